// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_ctrl
//  Description : Cache line refill controller. On a miss it first writes a
//                dirty victim line back to memory, then fetches the missing
//                line one word at a time and streams the words into the cache.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    localparam int IW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [DATA_W-1:0] victim_data,
    output logic [IW-1:0]     victim_idx,
    output logic              fill_we,
    output logic [IW-1:0]     fill_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              haultProcessor
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Low IW+2 address bits select the byte within a line; clearing them aligns a base.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((1 << (IW + 2)) - 1));
    localparam logic [IW-1:0]     LAST_WORD = IW'(WORDS - 1);

    logic [1:0]        state_q,     state_d;
    logic [IW-1:0]     cnt_q,       cnt_d;
    logic [ADDR_W-1:0] fill_base_q, fill_base_d;
    logic [ADDR_W-1:0] wb_base_q,   wb_base_d;
    logic [ADDR_W-1:0] word_off;

    // Word offset within the line; bases are aligned so OR-ing it in never carries.
    always_comb begin
        word_off           = '0;
        word_off[IW+1:0]   = {cnt_q, 2'b00};
    end

    // State register and datapath flops, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fill_base_q <= '0;
            wb_base_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_base_q <= fill_base_d;
            wb_base_q   <= wb_base_d;
        end
    end

    // Next-state logic: word counter only advances on an acknowledged transfer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_base_d = fill_base_q;
        wb_base_d   = wb_base_q;
        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    fill_base_d = miss_addr & LINE_MASK;
                    wb_base_d   = victim_addr & LINE_MASK;
                    cnt_d       = '0;
                    state_d     = victim_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; everything idles at zero.
    always_comb begin
        victim_idx = '0;
        fill_we    = 1'b0;
        fill_idx   = '0;
        fill_data  = '0;
        fill_done  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            S_WB: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = wb_base_q | word_off;
                mem_wdata  = victim_data;
                victim_idx = cnt_q;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_base_q | word_off;
                if (mem_ack) begin
                    fill_we   = 1'b1;
                    fill_idx  = cnt_q;
                    fill_data = mem_rdata;
                end
            end
            S_DONE: begin
                fill_done = 1'b1;
            end
            default: begin
            end
        endcase
        // Gated by reset so the stall is low while reset is asserted even with miss high.
        haultProcessor = reset & ((state_q != S_IDLE) | miss);
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_refill_ctrl
//  Description : Self-checking bench for cache_refill_ctrl (scoreboard of
//                expected memory transactions and fill writes).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_refill_ctrl;

    localparam logic [31:0] RD_KEY = 32'hA5A5_0000;
    localparam logic [31:0] VD_KEY = 32'hD000_0000;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        logic [1:0]  idx;
    } txn_t;

    logic        clk;
    logic        reset;
    logic        miss;
    logic [31:0] miss_addr;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic [31:0] victim_data;
    logic [1:0]  victim_idx;
    logic        fill_we;
    logic [1:0]  fill_idx;
    logic [31:0] fill_data;
    logic        fill_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        haultProcessor;

    int   errors = 0;
    int   checks = 0;
    txn_t exp_q[$];

    // Cache victim storage and memory read data are address-derived patterns.
    assign victim_data = VD_KEY | {30'b0, victim_idx};
    assign mem_rdata   = mem_addr ^ RD_KEY;

    cache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .WORDS(4)) dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr),
        .victim_data(victim_data), .victim_idx(victim_idx),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .fill_done(fill_done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .haultProcessor(haultProcessor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        miss = 1'b1; miss_addr = 32'h1234_5678; victim_dirty = 1'b1; victim_addr = 32'h8765_4320;
        #1;
        checks++; if ({mem_req, mem_we, fill_we, fill_done, haultProcessor} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, fill_we, fill_done, haultProcessor}); end
        checks++; if ({mem_addr, mem_wdata, fill_data} !== 96'b0) begin
            errors++; $display("FAIL reset_data: got %h %h %h want 0", mem_addr, mem_wdata, fill_data); end
        checks++; if ({victim_idx, fill_idx} !== 4'b0) begin
            errors++; $display("FAIL reset_idx: got %b %b want 0", victim_idx, fill_idx); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (haultProcessor !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL release_hault: got hault=%b req=%b want 1 0", haultProcessor, mem_req); end
        miss = 1'b0; victim_dirty = 1'b0;
        #1;
        checks++; if (haultProcessor !== 1'b0) begin
            errors++; $display("FAIL idle_hault: got %b want 0", haultProcessor); end
    endtask

    // Drives one miss sequence; the memory acks every cycle except for
    // stall_len cycles in front of transaction number stall_at.
    task automatic run_miss(input logic [31:0] maddr, input logic dirty, input logic [31:0] vaddr,
                            input int stall_at, input int stall_len, input string name);
        txn_t        t;
        int          popped;
        int          st;
        int          exp_done;
        bit          done;
        logic [31:0] fb;
        logic [31:0] vb;
        popped = 0; st = stall_len; done = 0;
        fb = maddr & 32'hFFFF_FFF0;
        vb = vaddr & 32'hFFFF_FFF0;
        exp_q.delete();
        if (dirty) for (int i = 0; i < 4; i++) begin
            t.addr = vb + 32'(4 * i); t.we = 1'b1; t.data = VD_KEY | 32'(i); t.idx = 2'(i);
            exp_q.push_back(t);
        end
        for (int i = 0; i < 4; i++) begin
            t.addr = fb + 32'(4 * i); t.we = 1'b0; t.data = (fb + 32'(4 * i)) ^ RD_KEY; t.idx = 2'(i);
            exp_q.push_back(t);
        end
        exp_done = 5 + (dirty ? 4 : 0) + stall_len;

        @(negedge clk);
        miss = 1'b1; miss_addr = maddr; victim_dirty = dirty; victim_addr = vaddr; mem_ack = 1'b1;
        #1;
        checks++; if (haultProcessor !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL %s miss_cycle: got hault=%b req=%b want 1 0", name, haultProcessor, mem_req); end
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            miss = 1'b0; victim_dirty = 1'b0;
            mem_ack = !(popped == stall_at && st > 0);
            if (!mem_ack) st--;
            #1;
            checks++; if (haultProcessor !== 1'b1) begin
                errors++; $display("FAIL %s hault c%0d: got %b want 1", name, cyc, haultProcessor); end
            if (exp_q.size() == 0) begin
                done = 1;
                checks++; if (fill_done !== 1'b1 || mem_req !== 1'b0) begin
                    errors++; $display("FAIL %s done: got done=%b req=%b want 1 0", name, fill_done, mem_req); end
                checks++; if (cyc != exp_done) begin
                    errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_done); end
            end else begin
                t = exp_q[0];
                checks++; if (mem_req !== 1'b1 || mem_addr !== t.addr || mem_we !== t.we) begin
                    errors++; $display("FAIL %s req c%0d: got req=%b addr=%h we=%b want 1 %h %b",
                                       name, cyc, mem_req, mem_addr, mem_we, t.addr, t.we); end
                if (t.we) begin
                    checks++; if (mem_wdata !== t.data || victim_idx !== t.idx) begin
                        errors++; $display("FAIL %s wdata c%0d: got %h idx=%0d want %h idx=%0d",
                                           name, cyc, mem_wdata, victim_idx, t.data, t.idx); end
                end
                if (mem_ack) begin
                    void'(exp_q.pop_front());
                    popped++;
                    checks++; if (fill_we !== !t.we || (!t.we && (fill_idx !== t.idx || fill_data !== t.data))) begin
                        errors++; $display("FAIL %s fill c%0d: got we=%b idx=%0d data=%h want %b %0d %h",
                                           name, cyc, fill_we, fill_idx, fill_data, !t.we, t.idx, t.data); end
                end else begin
                    checks++; if (fill_we !== 1'b0 || fill_done !== 1'b0) begin
                        errors++; $display("FAIL %s stall c%0d: got we=%b done=%b want 0 0", name, cyc, fill_we, fill_done); end
                end
            end
        end
        if (!done) begin
            errors++; checks++; $display("FAIL %s timeout: got no fill_done want fill_done", name);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (fill_done !== 1'b0 || haultProcessor !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL %s after_done: got done=%b hault=%b req=%b want 0 0 0",
                               name, fill_done, haultProcessor, mem_req); end
    endtask

    task automatic test_clean_miss();
        run_miss(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, -1, 0, "clean");
    endtask

    task automatic test_dirty_miss();
        run_miss(32'h0000_0000, 1'b1, 32'h0000_0014, -1, 0, "dirty");
    endtask

    task automatic test_stall();
        run_miss(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1, 3, "stall");
    endtask

    task automatic test_reset_midfill();
        @(negedge clk);
        miss = 1'b1; miss_addr = 32'h0000_0100; victim_dirty = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        miss = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || fill_we !== 1'b0 || haultProcessor !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL midfill_reset: got req=%b we=%b hault=%b addr=%h want 0 0 0 0",
                               mem_req, fill_we, haultProcessor, mem_addr); end
        @(negedge clk);
        #1;
        checks++; if (fill_done !== 1'b0) begin
            errors++; $display("FAIL midfill_no_done: got %b want 0", fill_done); end
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || haultProcessor !== 1'b0) begin
            errors++; $display("FAIL midfill_idle: got req=%b hault=%b want 0 0", mem_req, haultProcessor); end
        run_miss(32'h0000_0208, 1'b0, 32'h0000_0000, -1, 0, "restart");
    endtask

    task automatic test_back_to_back();
        bit seen;
        @(negedge clk);
        miss = 1'b1; miss_addr = 32'h0000_0040; victim_dirty = 1'b0; mem_ack = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            miss = (cyc == 2);
            miss_addr = (cyc >= 2) ? 32'h0000_0080 : 32'h0000_0040;
            #1;
            checks++; if (mem_addr !== 32'h40 + 32'(4 * (cyc - 1)) || fill_we !== 1'b1 || fill_idx !== 2'(cyc - 1)) begin
                errors++; $display("FAIL b2b_first c%0d: got addr=%h we=%b idx=%0d want %h 1 %0d",
                                   cyc, mem_addr, fill_we, fill_idx, 32'h40 + 32'(4 * (cyc - 1)), cyc - 1); end
        end
        @(negedge clk);
        miss = 1'b1;
        #1;
        checks++; if (fill_done !== 1'b1) begin
            errors++; $display("FAIL b2b_done: got %b want 1", fill_done); end
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0 || fill_done !== 1'b0 || haultProcessor !== 1'b1) begin
            errors++; $display("FAIL b2b_idle: got req=%b done=%b hault=%b want 0 0 1", mem_req, fill_done, haultProcessor); end
        @(negedge clk);
        miss = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0080) begin
            errors++; $display("FAIL b2b_second: got req=%b we=%b addr=%h want 1 0 00000080", mem_req, mem_we, mem_addr); end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (fill_done === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin
            errors++; $display("FAIL b2b_timeout: got no fill_done want fill_done"); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; miss = 1'b0; miss_addr = '0; victim_dirty = 1'b0; victim_addr = '0; mem_ack = 1'b0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_stall();
        test_reset_midfill();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
